pipe_mux_tree: RTL and testbench

Parametrised, pipelined N:1 word multiplexer for the datapath (register-read, forwarding and writeback selection). Built as a tree of radix-4 levels. Every level is registered, so wide and deep selections close timing at CPU clock rate. A valid bit and the select tag travel with the data. Global stall and flush hooks let the block sit directly inside the 5-stage pipeline control.

---
 rtl/mux_pkg.sv | 24 ++
 rtl/pipe_mux_level.sv | 80 ++++++++
 rtl/pipe_mux_tree.sv | 84 ++++++++
 tb/tb_pipe_mux_tree.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// mux_pkg: shared definitions for the pipelined word multiplexer tree.
//   RADIX       - fan-in of a full tree level
//   MAX_SELW    - widest select tag the control struct can carry
//   levels_f()  - number of registered levels for a given select width
//   stage_ctl_t - control word that travels with the data (valid + tag)
package mux_pkg;

  localparam int RADIX = 4;
  localparam int MAX_SELW = 32;

  // Each radix-4 level consumes two select bits; an odd leftover bit
  // becomes one final radix-2 level.
  function automatic int levels_f(input int sel_w);
    return (sel_w + 1) / 2;
  endfunction

  // The tag field is sized for the widest supported select. An instance
  // only uses the low SELW bits, and the unused upper bits stay zero.
  typedef struct packed {
    logic                valid;
    logic [MAX_SELW-1:0] sel;
  } stage_ctl_t;

endpackage

// File: rtl/pipe_mux_level.sv
// pipe_mux_level: one registered level of the multiplexer tree.
//   clk, reset    - clock (rising edge), asynchronous active-low reset
//   stall, flush  - freeze all registers / clear the valid bit
//   in_ctl        - valid + select tag from the previous level (or input)
//   in_words      - NIN words, word i at [i*WIDTH +: WIDTH]
//   out_ctl       - registered valid + tag
//   out_words     - NIN/RADIX_L registered surviving words
module pipe_mux_level
  import mux_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int NIN     = 4,
  parameter int RADIX_L = RADIX,
  parameter int SELW    = 4,
  parameter int LVL     = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             flush,
  input  stage_ctl_t                       in_ctl,
  input  logic [NIN*WIDTH-1:0]             in_words,
  output stage_ctl_t                       out_ctl,
  output logic [(NIN/RADIX_L)*WIDTH-1:0]   out_words
);

  localparam int NOUT = NIN / RADIX_L;
  localparam int SB   = (RADIX_L == 4) ? 2 : 1;

  logic [SELW-1:0]       tag;
  logic [SB-1:0]         pick;
  logic                  load;
  logic [NOUT*WIDTH-1:0] next_words;
  logic                  valid_q;
  logic [SELW-1:0]       sel_q;
  logic                  unused_tag_hi;

  assign tag           = in_ctl.sel[SELW-1:0];
  assign unused_tag_hi = ^in_ctl.sel[MAX_SELW-1:SELW];
  assign pick          = tag[2*LVL +: SB];

  // Data and tag only move when a live entry arrives and the pipe advances,
  // so bubbles leave the last valid result sitting in the registers.
  assign load = in_ctl.valid & ~stall & ~flush;

  // Every output word j picks one of the RADIX_L words in its group using
  // this level's slice of the select tag.
  always_comb begin
    next_words = '0;
    for (int j = 0; j < NOUT; j++) begin
      next_words[j*WIDTH +: WIDTH] = in_words[(j*RADIX_L + int'(pick))*WIDTH +: WIDTH];
    end
  end

  // Valid bit: flush wins over stall and clears it; stall holds it;
  // otherwise it follows the incoming valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (!stall) begin
      valid_q <= in_ctl.valid;
    end
  end

  // Surviving words and the full select tag, captured with a live entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q     <= '0;
      out_words <= '0;
    end else if (load) begin
      sel_q     <= tag;
      out_words <= next_words;
    end
  end

  assign out_ctl = '{valid: valid_q, sel: MAX_SELW'(sel_q)};

endmodule

// File: rtl/pipe_mux_tree.sv
// pipe_mux_tree: pipelined N:1 word multiplexer built from registered
// radix-4 levels (a final radix-2 level when the select width is odd).
//   clk, reset  - clock (rising edge), asynchronous active-low reset
//   in_valid    - in_data/sel are valid this cycle
//   in_data     - N words, word i at [i*WIDTH +: WIDTH]
//   sel         - index of the word to select
//   stall       - freeze every pipeline register
//   flush       - clear every in-flight valid bit (priority over stall)
//   out_valid   - out_data/out_sel carry a valid result
//   out_data    - selected word
//   out_sel     - select value that produced out_data
module pipe_mux_tree
  import mux_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int N = 16,
  localparam int SELW = $clog2(N),
  localparam int LEVELS = levels_f(SELW)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SELW-1:0]    sel,
  input  logic               stall,
  input  logic               flush,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel
);

  stage_ctl_t head_ctl;

  assign head_ctl = '{valid: in_valid, sel: MAX_SELW'(sel)};

  for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
    // Word count shrinks by 4 per level; only the last level of an
    // odd-width select is radix-2.
    localparam int NIN  = N >> (2*k);
    localparam int RAD  = ((k == LEVELS-1) && (SELW % 2 == 1)) ? 2 : RADIX;
    localparam int NOUT = NIN / RAD;

    stage_ctl_t             ctl_in;
    stage_ctl_t             ctl_out;
    logic [NIN*WIDTH-1:0]   words_in;
    logic [NOUT*WIDTH-1:0]  words_out;

    if (k == 0) begin : g_first
      assign ctl_in   = head_ctl;
      assign words_in = in_data;
    end else begin : g_next
      assign ctl_in   = g_lvl[k-1].ctl_out;
      assign words_in = g_lvl[k-1].words_out;
    end

    pipe_mux_level #(
      .WIDTH   (WIDTH),
      .NIN     (NIN),
      .RADIX_L (RAD),
      .SELW    (SELW),
      .LVL     (k)
    ) u_level (
      .clk       (clk),
      .reset     (reset),
      .stall     (stall),
      .flush     (flush),
      .in_ctl    (ctl_in),
      .in_words  (words_in),
      .out_ctl   (ctl_out),
      .out_words (words_out)
    );

    // The last level's registers drive the outputs directly, so there is
    // no combinational path from any input to any output.
    if (k == LEVELS-1) begin : g_last
      logic unused_tag_hi;
      assign unused_tag_hi = ^ctl_out.sel[MAX_SELW-1:SELW];
      assign out_valid     = ctl_out.valid;
      assign out_sel       = ctl_out.sel[SELW-1:0];
      assign out_data      = words_out;
    end
  end

endmodule

// File: tb/tb_pipe_mux_tree.sv
// tb_pipe_mux_tree: self-checking bench for pipe_mux_tree.
// Main instance: N=16, WIDTH=8 (two radix-4 levels).
// Second instance: N=8, WIDTH=16 (radix-4 then radix-2).
module tb_pipe_mux_tree;

  localparam int W  = 8;
  localparam int N1 = 16;
  localparam int S1 = 4;
  localparam int L1 = 2;
  localparam int W2 = 16;
  localparam int N2 = 8;
  localparam int S2 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic              stall;
  logic              flush;
  logic              in_valid;
  logic [N1*W-1:0]   in_data;
  logic [S1-1:0]     sel;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic [S1-1:0]     out_sel;

  logic              in_valid2;
  logic [N2*W2-1:0]  in_data2;
  logic [S2-1:0]     sel2;
  logic              out_valid2;
  logic [W2-1:0]     out_data2;
  logic [S2-1:0]     out_sel2;

  int checks = 0;
  int passes = 0;

  pipe_mux_tree #(.WIDTH(W), .N(N1)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .sel       (sel),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel)
  );

  pipe_mux_tree #(.WIDTH(W2), .N(N2)) dut_odd (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid2),
    .in_data   (in_data2),
    .sel       (sel2),
    .stall     (stall),
    .flush     (flush),
    .out_valid (out_valid2),
    .out_data  (out_data2),
    .out_sel   (out_sel2)
  );

  // Reference model: a LEVELS-deep delay line of already-selected words.
  // Selection is done in one step straight from in_data; the delay line
  // applies the stall/flush/bubble-hold rules.
  logic          mv [L1];
  logic [W-1:0]  md [L1];
  logic [S1-1:0] ms [L1];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < L1; i++) begin
        mv[i] <= 1'b0;
        md[i] <= '0;
        ms[i] <= '0;
      end
    end else if (flush) begin
      for (int i = 0; i < L1; i++) mv[i] <= 1'b0;
    end else if (!stall) begin
      mv[0] <= in_valid;
      if (in_valid) begin
        md[0] <= in_data[sel*W +: W];
        ms[0] <= sel;
      end
      for (int i = 1; i < L1; i++) begin
        mv[i] <= mv[i-1];
        if (mv[i-1]) begin
          md[i] <= md[i-1];
          ms[i] <= ms[i-1];
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_data !== 8'h00) $display("[TB] FAIL reset_data: got %h expected 00", out_data); else passes++;
    checks++; if (out_sel !== 4'd0) $display("[TB] FAIL reset_sel: got %0d expected 0", out_sel); else passes++;
    checks++; if (out_valid2 !== 1'b0) $display("[TB] FAIL reset_valid_odd: got %b expected 0", out_valid2); else passes++;
  endtask

  task automatic test_basic();
    in_valid = 1'b1;
    sel = 4'd9;
    cyc();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL basic_early: got %b expected 0", out_valid); else passes++;
    cyc();
    checks++; if (out_valid !== 1'b1) $display("[TB] FAIL basic_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 8'h99) $display("[TB] FAIL basic_data: got %h expected 99", out_data); else passes++;
    checks++; if (out_sel !== 4'd9) $display("[TB] FAIL basic_sel: got %0d expected 9", out_sel); else passes++;
    cyc();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL basic_drop: got %b expected 0", out_valid); else passes++;
    checks++; if (out_data !== 8'h99) $display("[TB] FAIL basic_hold: got %h expected 99", out_data); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] s [3];
    logic [7:0] e [3];
    s = '{4'd0, 4'd5, 4'd15};
    e = '{8'h00, 8'h55, 8'hFF};
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin
        in_valid = 1'b1;
        sel = s[i];
      end else begin
        in_valid = 1'b0;
      end
      cyc();
      if (i >= 1 && i <= 3) begin
        checks++; if (out_valid !== 1'b1) $display("[TB] FAIL b2b_valid_%0d: got %b expected 1", i, out_valid); else passes++;
        checks++; if (out_data !== e[i-1]) $display("[TB] FAIL b2b_data_%0d: got %h expected %h", i, out_data, e[i-1]); else passes++;
      end else if (i == 4) begin
        checks++; if (out_valid !== 1'b0) $display("[TB] FAIL b2b_end: got %b expected 0", out_valid); else passes++;
      end
    end
  endtask

  task automatic test_flush();
    in_valid = 1'b1;
    sel = 4'd7;
    cyc();
    in_valid = 1'b0;
    flush = 1'b1;
    stall = 1'b1;
    cyc();
    flush = 1'b0;
    stall = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_valid0: got %b expected 0", out_valid); else passes++;
    checks++; if (out_data !== 8'hFF) $display("[TB] FAIL flush_data0: got %h expected FF", out_data); else passes++;
    cyc();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_valid1: got %b expected 0", out_valid); else passes++;
    checks++; if (out_data !== 8'hFF) $display("[TB] FAIL flush_data1: got %h expected FF", out_data); else passes++;
    checks++; if (out_sel !== 4'd15) $display("[TB] FAIL flush_sel: got %0d expected 15", out_sel); else passes++;
  endtask

  task automatic test_stall();
    in_valid = 1'b1;
    sel = 4'd3;
    cyc();
    stall = 1'b1;
    sel = 4'd12;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (out_valid !== 1'b0) $display("[TB] FAIL stall_valid_%0d: got %b expected 0", i, out_valid); else passes++;
      checks++; if (out_data !== 8'hFF) $display("[TB] FAIL stall_data_%0d: got %h expected FF", i, out_data); else passes++;
    end
    stall = 1'b0;
    in_valid = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b1) $display("[TB] FAIL stall_emerge_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 8'h33) $display("[TB] FAIL stall_emerge_data: got %h expected 33", out_data); else passes++;
    checks++; if (out_sel !== 4'd3) $display("[TB] FAIL stall_emerge_sel: got %0d expected 3", out_sel); else passes++;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++; if (out_valid !== 1'b0) $display("[TB] FAIL stall_after_valid_%0d: got %b expected 0", i, out_valid); else passes++;
      checks++; if (out_sel !== 4'd3) $display("[TB] FAIL stall_after_sel_%0d: got %0d expected 3", i, out_sel); else passes++;
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    sel = 4'd1;
    cyc();
    sel = 4'd2;
    cyc();
    in_valid = 1'b0;
    checks++; if (out_data !== 8'h11) $display("[TB] FAIL arst_pre_data: got %h expected 11", out_data); else passes++;
    #2 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL arst_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_data !== 8'h00) $display("[TB] FAIL arst_data: got %h expected 00", out_data); else passes++;
    checks++; if (out_sel !== 4'd0) $display("[TB] FAIL arst_sel: got %0d expected 0", out_sel); else passes++;
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b1;
    sel = 4'd10;
    cyc();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL arst_flushed: got %b expected 0", out_valid); else passes++;
    cyc();
    checks++; if (out_valid !== 1'b1) $display("[TB] FAIL arst_new_valid: got %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 8'hAA) $display("[TB] FAIL arst_new_data: got %h expected AA", out_data); else passes++;
    checks++; if (out_sel !== 4'd10) $display("[TB] FAIL arst_new_sel: got %0d expected 10", out_sel); else passes++;
  endtask

  task automatic test_odd_selw();
    logic [2:0]  s;
    logic [2:0]  prev;
    logic [15:0] exp_d;
    prev = '0;
    for (int i = 0; i < 10; i++) begin
      s = 3'((i*3 + 1) % 8);
      if (i < 8) begin
        in_valid2 = 1'b1;
        sel2 = s;
      end else begin
        in_valid2 = 1'b0;
      end
      cyc();
      if (i >= 1 && i <= 8) begin
        exp_d = 16'hA0 + 16'(prev);
        checks++; if (out_valid2 !== 1'b1) $display("[TB] FAIL odd_valid_%0d: got %b expected 1", i, out_valid2); else passes++;
        checks++; if (out_data2 !== exp_d) $display("[TB] FAIL odd_data_%0d: got %h expected %h", i, out_data2, exp_d); else passes++;
        checks++; if (out_sel2 !== prev) $display("[TB] FAIL odd_sel_%0d: got %0d expected %0d", i, out_sel2, prev); else passes++;
      end else if (i == 9) begin
        checks++; if (out_valid2 !== 1'b0) $display("[TB] FAIL odd_end: got %b expected 0", out_valid2); else passes++;
      end
      prev = s;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      checks++; if (out_valid !== mv[L1-1]) $display("[TB] FAIL rnd_valid_%0d: got %b expected %b", c, out_valid, mv[L1-1]); else passes++;
      checks++; if (out_data !== md[L1-1]) $display("[TB] FAIL rnd_data_%0d: got %h expected %h", c, out_data, md[L1-1]); else passes++;
      checks++; if (out_sel !== ms[L1-1]) $display("[TB] FAIL rnd_sel_%0d: got %0d expected %0d", c, out_sel, ms[L1-1]); else passes++;
      in_valid = ($urandom_range(0, 3) != 0);
      sel = 4'($urandom_range(0, N1-1));
      for (int k = 0; k < 4; k++) in_data[k*32 +: 32] = $urandom;
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 9) == 0);
      cyc();
    end
    stall = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    sel = '0;
    in_valid2 = 1'b0;
    sel2 = '0;
    for (int i = 0; i < N1; i++) in_data[i*W +: W] = {4'(i), 4'(i)};
    for (int i = 0; i < N2; i++) in_data2[i*W2 +: W2] = 16'hA0 + 16'(i);
    repeat (2) @(negedge clk);
    test_reset();
    reset = 1'b1;
    @(negedge clk);
    test_basic();
    test_back_to_back();
    test_flush();
    test_stall();
    test_async_reset();
    test_odd_selw();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
